// File: rtl/fifo_pkg.sv
// Shared types and helpers for the programmable synchronous FIFO.
// Provides the read-mode enum and the occupancy-count width helper.
package fifo_pkg;

  typedef enum logic {
    FIFO_STD,
    FIFO_FWFT
  } fifo_mode_e;

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_sdp_ram.sv
// Simple dual-port RAM: one write port, one synchronous read port.
// Ports: clk, i_rst (clears only the read register), i_we/i_waddr/i_wdata, i_re/i_raddr, o_rdata.
module fifo_sdp_ram #(
  parameter int DATA_WIDTH = 18,
  parameter int DEPTH      = 512
) (
  input  logic                     clk,
  input  logic                     i_rst,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0]    i_wdata,
  input  logic                     i_re,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0]    o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Only the output register is reset so the array still maps to block RAM.
  always_ff @(posedge clk) begin
    if (i_rst)     r_q <= '0;
    else if (i_re) r_q <= r_mem[i_raddr];
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with STD/FWFT read mode, programmable thresholds and reset-busy window.
// Ports: clk, rst, din/wr_en, rd_en/dout/data_valid, full/empty, prog_full/prog_empty, data_count, overflow/underflow, rst_busy.
module sync_fifo_prog
  import fifo_pkg::*;
#(
  parameter int         DATA_WIDTH        = 18,
  parameter int         DEPTH             = 512,
  parameter fifo_mode_e MODE              = FIFO_STD,
  parameter int         PROG_FULL_THRESH  = DEPTH - 4,
  parameter int         PROG_EMPTY_THRESH = 4,
  parameter int         RST_BUSY_CYCLES   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     din,
  input  logic                      wr_en,
  input  logic                      rd_en,
  output logic [DATA_WIDTH-1:0]     dout,
  output logic                      data_valid,
  output logic                      full,
  output logic                      empty,
  output logic                      prog_full,
  output logic                      prog_empty,
  output logic [cnt_w(DEPTH)-1:0]   data_count,
  output logic                      overflow,
  output logic                      underflow,
  output logic                      rst_busy
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = cnt_w(DEPTH);
  localparam int BW   = $clog2(RST_BUSY_CYCLES + 1);
  localparam bit FWFT = (MODE == FIFO_FWFT);

  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] PF_C   = CW'(PROG_FULL_THRESH);
  localparam logic [CW-1:0] PE_C   = CW'(PROG_EMPTY_THRESH);

  if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $fatal(1, "DEPTH must be a power of two >= 4");
  end
  if ((PROG_FULL_THRESH < 1) || (PROG_FULL_THRESH > DEPTH)) begin : g_bad_pf
    $fatal(1, "PROG_FULL_THRESH out of range");
  end
  if ((PROG_EMPTY_THRESH < 0) || (PROG_EMPTY_THRESH > DEPTH - 1)) begin : g_bad_pe
    $fatal(1, "PROG_EMPTY_THRESH out of range");
  end
  if (RST_BUSY_CYCLES < 1) begin : g_bad_busy
    $fatal(1, "RST_BUSY_CYCLES must be >= 1");
  end

  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic [BW-1:0]     r_busy_cnt;
  logic              r_full;
  logic              r_empty;
  logic              r_pfull;
  logic              r_pempty;
  logic              r_valid;
  logic              r_ovf;
  logic              r_udf;

  logic              w_busy;
  logic              w_empty;
  logic              w_wr;
  logic              w_rd;
  logic              w_ram_has;
  logic              w_ram_re;
  logic              w_valid_nxt;
  logic [CW-1:0]     w_cnt_nxt;
  logic [DATA_WIDTH-1:0] w_ram_q;

  assign w_busy    = (r_busy_cnt != '0);
  assign w_ram_has = (r_wr_ptr != r_rd_ptr);
  assign w_empty   = FWFT ? ~r_valid : r_empty;
  assign w_wr      = wr_en & ~r_full & ~w_busy;
  assign w_rd      = rd_en & ~w_empty & ~w_busy;

  // FWFT refills the output register whenever it is idle or being popped.
  assign w_ram_re  = FWFT ? (w_ram_has & (~r_valid | w_rd)) : w_rd;

  always_comb begin
    w_valid_nxt = w_rd;
    if (FWFT) begin
      w_valid_nxt = w_ram_re | (r_valid & ~w_rd);
    end
  end

  always_comb begin
    w_cnt_nxt = r_count;
    if (w_wr & ~w_rd) w_cnt_nxt = r_count + CW'(1);
    if (~w_wr & w_rd) w_cnt_nxt = r_count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_busy_cnt <= BW'(RST_BUSY_CYCLES);
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_pfull    <= 1'b0;
      r_pempty   <= 1'b1;
      r_valid    <= 1'b0;
      r_ovf      <= 1'b0;
      r_udf      <= 1'b0;
    end else begin
      if (w_busy)   r_busy_cnt <= r_busy_cnt - BW'(1);
      if (w_wr)     r_wr_ptr   <= r_wr_ptr + (AW+1)'(1);
      if (w_ram_re) r_rd_ptr   <= r_rd_ptr + (AW+1)'(1);
      r_count  <= w_cnt_nxt;
      r_full   <= (w_cnt_nxt == FULL_C);
      r_empty  <= (w_cnt_nxt == '0);
      r_pfull  <= (w_cnt_nxt >= PF_C);
      r_pempty <= (w_cnt_nxt <= PE_C);
      r_valid  <= w_valid_nxt;
      r_ovf    <= wr_en & r_full & ~w_busy;
      r_udf    <= rd_en & w_empty & ~w_busy;
    end
  end

  fifo_sdp_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk     (clk),
    .i_rst   (rst),
    .i_we    (w_wr),
    .i_waddr (r_wr_ptr[AW-1:0]),
    .i_wdata (din),
    .i_re    (w_ram_re),
    .i_raddr (r_rd_ptr[AW-1:0]),
    .o_rdata (w_ram_q)
  );

  assign dout       = w_ram_q;
  assign data_valid = r_valid;
  assign full       = r_full;
  assign empty      = w_empty;
  assign prog_full  = r_pfull;
  assign prog_empty = r_pempty;
  assign data_count = r_count;
  assign overflow   = r_ovf;
  assign underflow  = r_udf;
  assign rst_busy   = w_busy;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Bench for sync_fifo_prog: STD and FWFT instances driven in lockstep
// and compared each cycle against queue-based reference models.
module tb_sync_fifo_prog;
  import fifo_pkg::*;

  localparam int DW = 18;
  localparam int D  = 16;
  localparam int PF = 12;
  localparam int PE = 4;
  localparam int RB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic          rd_en;
  logic [DW-1:0] din;

  logic [DW-1:0] s_dout, f_dout;
  logic          s_dv, s_full, s_empty, s_pf, s_pe, s_ovf, s_udf, s_busy;
  logic          f_dv, f_full, f_empty, f_pf, f_pe, f_ovf, f_udf, f_busy;
  logic [4:0]    s_cnt, f_cnt;

  always #5 clk = ~clk;

  sync_fifo_prog #(
    .DATA_WIDTH(DW), .DEPTH(D), .MODE(FIFO_STD),
    .PROG_FULL_THRESH(PF), .PROG_EMPTY_THRESH(PE), .RST_BUSY_CYCLES(RB)
  ) u_std (
    .clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .rd_en(rd_en),
    .dout(s_dout), .data_valid(s_dv), .full(s_full), .empty(s_empty),
    .prog_full(s_pf), .prog_empty(s_pe), .data_count(s_cnt),
    .overflow(s_ovf), .underflow(s_udf), .rst_busy(s_busy)
  );

  sync_fifo_prog #(
    .DATA_WIDTH(DW), .DEPTH(D), .MODE(FIFO_FWFT),
    .PROG_FULL_THRESH(PF), .PROG_EMPTY_THRESH(PE), .RST_BUSY_CYCLES(RB)
  ) u_fwft (
    .clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .rd_en(rd_en),
    .dout(f_dout), .data_valid(f_dv), .full(f_full), .empty(f_empty),
    .prog_full(f_pf), .prog_empty(f_pe), .data_count(f_cnt),
    .overflow(f_ovf), .underflow(f_udf), .rst_busy(f_busy)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    int            ts;
  } ent_t;

  logic [DW-1:0] qs[$];
  ent_t          qf[$];
  int            ecnt;
  int            since;
  logic          m_sdv, m_fdv, m_sovf, m_sudf, m_fovf, m_fudf;
  logic [DW-1:0] m_sdo, m_fdo;
  int            n_cmp;
  int            n_bad;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit   busy;
    bit   acc_w;
    ent_t e;
    ecnt++;
    if (rst) begin
      qs.delete();
      qf.delete();
      m_sdv = 0; m_fdv = 0;
      m_sdo = '0; m_fdo = '0;
      m_sovf = 0; m_sudf = 0;
      m_fovf = 0; m_fudf = 0;
      since = 0;
    end else begin
      busy = (since < RB);
      // STD: read returns the head one cycle later
      acc_w  = wr_en && qs.size() < D && !busy;
      m_sovf = wr_en && qs.size() == D && !busy;
      m_sudf = rd_en && qs.size() == 0 && !busy;
      m_sdv  = rd_en && qs.size() != 0 && !busy;
      if (m_sdv) m_sdo = qs.pop_front();
      if (acc_w) qs.push_back(din);
      // FWFT: head is visible once stored before the current edge
      acc_w  = wr_en && qf.size() < D && !busy;
      m_fovf = wr_en && qf.size() == D && !busy;
      m_fudf = rd_en && !m_fdv && !busy;
      if (rd_en && m_fdv && !busy) void'(qf.pop_front());
      if (acc_w) begin
        e.d  = din;
        e.ts = ecnt;
        qf.push_back(e);
      end
      if (qf.size() > 0 && qf[0].ts < ecnt) begin
        m_fdv = 1;
        m_fdo = qf[0].d;
      end else begin
        m_fdv = 0;
      end
      if (since < RB) since++;
    end
  endtask

  task automatic check_all();
    check("std.count",  32'(s_cnt),   qs.size());
    check("std.full",   32'(s_full),  32'(qs.size() == D));
    check("std.empty",  32'(s_empty), 32'(qs.size() == 0));
    check("std.pfull",  32'(s_pf),    32'(qs.size() >= PF));
    check("std.pempty", 32'(s_pe),    32'(qs.size() <= PE));
    check("std.valid",  32'(s_dv),    32'(m_sdv));
    check("std.dout",   32'(s_dout),  32'(m_sdo));
    check("std.ovf",    32'(s_ovf),   32'(m_sovf));
    check("std.udf",    32'(s_udf),   32'(m_sudf));
    check("std.busy",   32'(s_busy),  32'(since < RB));
    check("fw.count",   32'(f_cnt),   qf.size());
    check("fw.full",    32'(f_full),  32'(qf.size() == D));
    check("fw.empty",   32'(f_empty), 32'(!m_fdv));
    check("fw.pfull",   32'(f_pf),    32'(qf.size() >= PF));
    check("fw.pempty",  32'(f_pe),    32'(qf.size() <= PE));
    check("fw.valid",   32'(f_dv),    32'(m_fdv));
    check("fw.dout",    32'(f_dout),  32'(m_fdo));
    check("fw.ovf",     32'(f_ovf),   32'(m_fovf));
    check("fw.udf",     32'(f_udf),   32'(m_fudf));
    check("fw.busy",    32'(f_busy),  32'(since < RB));
  endtask

  task automatic step(input logic w, input logic r, input logic rs,
                      input logic [DW-1:0] d);
    wr_en = w;
    rd_en = r;
    rst   = rs;
    din   = d;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    ecnt  = 0;
    since = 0;
    rst   = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    din   = '0;
    #1;
    step(1, 0, 1, DW'($urandom));
    step(1, 0, 1, DW'($urandom));
    for (int i = 0; i < RB; i++) step(1, 0, 0, DW'($urandom));
    for (int i = 0; i < D + 2; i++) step(1, 0, 0, DW'(i));
    for (int i = 0; i < D + 2; i++) step(0, 1, 0, '0);
    step(1, 0, 0, DW'('h2A5));
    step(0, 0, 0, '0);
    step(0, 1, 0, '0);
    step(0, 1, 0, '0);
    step(0, 0, 0, '0);
    for (int i = 0; i < 8; i++) step(1, 0, 0, DW'($urandom));
    step(0, 0, 0, '0);
    for (int i = 0; i < 100; i++) step(1, 1, 0, DW'($urandom));
    for (int b = 0; b < 6; b++) begin
      for (int i = 0; i < 80; i++) begin
        step(($urandom_range(0, 99) < ((b % 2 == 0) ? 70 : 30)),
             ($urandom_range(0, 99) < ((b % 2 == 0) ? 30 : 70)),
             ($urandom_range(0, 149) == 0),
             DW'($urandom));
      end
    end
    for (int i = 0; i < D + 2; i++) step(0, 1, 0, '0);
    for (int i = 0; i < 10; i++) step(1, 0, 0, DW'($urandom));
    step(0, 1, 1, '0);
    for (int i = 0; i < RB + 2; i++) step(0, 1, 0, '0);
    step(1, 0, 0, DW'('h1234));
    for (int i = 0; i < 4; i++) step(0, 1, 0, '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sync_fifo_prog.md
Name: sync_fifo_prog

Overview:
Single-clock parametrised FIFO that replaces vendor FIFO-generator instances behind the existing fifo_if signal set.
- Adds selectable standard or first-word-fall-through (FWFT) read mode.
- Adds programmable full and empty thresholds, occupancy count and sticky-free overflow/underflow pulses.
- Emulates a post-reset busy window.
- Sits between MMIO/stream producers and consumers inside one clock domain.

Parameters:
DATA_WIDTH, 18, word width in bits
DEPTH, 512, capacity in words; power of two, minimum 4
MODE, FIFO_STD, read mode: FIFO_STD or FIFO_FWFT (fifo_mode_e)
PROG_FULL_THRESH, DEPTH-4, prog_full asserted when data_count >= this; range 1..DEPTH
PROG_EMPTY_THRESH, 4, prog_empty asserted when data_count <= this; range 0..DEPTH-1
RST_BUSY_CYCLES, 4, cycles rst_busy stays high after rst deasserts; minimum 1

Ports:
clk  in  1  single clock, all logic rising-edge
rst  in  1  synchronous active-high reset
din  in  DATA_WIDTH  write data
wr_en  in  1  write request
rd_en  in  1  read request (FWFT: acknowledge of the presented word)
dout  out  DATA_WIDTH  read data
data_valid  out  1  dout holds a valid word
full  out  1  data_count == DEPTH
empty  out  1  no readable word
prog_full  out  1  programmable full
prog_empty  out  1  programmable empty
data_count  out  $clog2(DEPTH)+1  words held
overflow  out  1  one-cycle pulse: rejected write
underflow  out  1  one-cycle pulse: rejected read
rst_busy  out  1  FIFO not accepting requests

Behaviour:
- Reset: one clock, rst=1, synchronous and active-high.
- Reset values: pointers=0, data_count=0, empty=1, full=0, prog_full=0, prog_empty=1, data_valid=0, dout=0, overflow=0, underflow=0, rst_busy=1.
- rst mid-operation discards all contents immediately at that edge.
- rst_busy: a counter holds rst_busy=1 for RST_BUSY_CYCLES edges after the last rst=1 edge, then 0.
- While rst_busy=1, wr_en and rd_en are ignored and raise no overflow or underflow.
- Pointers: AW=$clog2(DEPTH), width AW+1. Address is the low AW bits and wraps naturally; the MSB disambiguates full from empty.
- Capacity is exactly DEPTH in both modes; the FWFT output register counts toward data_count.
- Write accept rule: wr_en & ~full & ~rst_busy.
- A write while full is dropped, storage is unchanged, and overflow=1 after that edge for one cycle.
- A simultaneous read does not free space for that same cycle's write.
- STD read accept rule: rd_en & ~empty & ~rst_busy.
- STD read latency is 1: an accept at edge r gives dout=word and data_valid=1 after edge r.
- STD data_valid is 1 for exactly one cycle per accepted read. dout holds its last value otherwise.
- STD empty deasserts after the edge that writes into an empty FIFO.
- FWFT: the head word is prefetched into the output register.
- FWFT: a word written at edge k into an empty FIFO is presented after edge k+1 with data_valid=1 and empty=0.
- FWFT: empty = ~data_valid.
- FWFT: rd_en & data_valid pops the word. The next word is presented after the same edge if one is stored, else data_valid=0.
- Underflow: rd_en while empty (and not rst_busy) pulses underflow for one cycle and leaves state unchanged.
- data_count update: +1 on an accepted write only, -1 on an accepted read only, unchanged on both or neither. Registered, updated at the same edge as the accept.
- full, prog_full and prog_empty are registered, derived from the next-state count, and change at the same edge as data_count.
- Write into empty plus read request in the same cycle: the write is accepted and the read underflows.

Decomposition:
- fifo_pkg: typedef enum fifo_mode_e {FIFO_STD, FIFO_FWFT}; function clog2-based count-width helper.
- Elaboration-time parameter checks (power-of-two DEPTH, threshold ranges) issue $fatal.
- Sub-module fifo_sdp_ram: simple dual-port RAM with DATA_WIDTH x DEPTH, one write port, one synchronous-read port, and no reset on the array. This lets the tools infer BRAM or LUTRAM.
- Control, counters, flags and the FWFT prefetch live in sync_fifo_prog.

Test Plan:
- Reset release, RST_BUSY_CYCLES=4, wr_en held 1 → no writes, data_count=0 and no overflow for 4 cycles after rst drops; first write accepted on edge 5.
- STD, DEPTH=16: write 0x00..0x0F, then 1 more → full=1, data_count=16, overflow pulses once, and reading 16 words returns 0x00..0x0F in order with one data_valid per read.
- FWFT: single write 0x2A5 at edge k → dout=0x2A5, data_valid=1 after edge k+1; rd_en → empty=1 next cycle; a further rd_en → underflow pulse.
- Thresholds at DEPTH=16, PF=12, PE=4: fill to 11 → prog_full=0; fill to 12 → prog_full=1; drain to 5 → prog_empty=0; drain to 4 → prog_empty=1.
- Simultaneous wr_en and rd_en at data_count=8 for 100 cycles of random data → data_count stays 8 and the output sequence matches the reference queue; wraparound exercised.
- Assert rst with data_count=10 → next cycle empty=1, data_count=0, data_valid=0, and the old data is never presented.
